// File: rtl/par_fifo_buffer.sv
// par_fifo_buffer: parametrised first-word-fall-through FIFO with a variable
// number of write lanes per cycle, fixed-width pops, arbitrary (non power of
// two) depth, programmable almost-full/almost-empty levels and sticky
// overflow/underflow error flags.
module par_fifo_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 4,
    parameter int PAR_READ   = 2,
    parameter int DEPTH      = 10,
    parameter int AF_LEVEL   = 8,
    parameter int AE_LEVEL   = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear,
    input  logic                               wen,
    input  logic [$clog2(PAR_WRITE+1)-1:0]     wcount,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0]    din,
    input  logic                               ren,
    output logic [PAR_READ*DATA_WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    int   cnt_i;
    int   wc_i;
    int   free_w;
    logic wr_req, wr_fit, wr_acc, wr_rej;
    logic rd_acc, rd_rej;

    // Pointer advance modulo DEPTH; p < DEPTH and n <= DEPTH, so a single
    // conditional subtraction is enough for any depth.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Request qualification; free space is the pre-edge value, so a pop in the
    // same cycle never makes room for a push. clear drops both requests.
    always_comb begin
        cnt_i  = int'(count_q);
        wc_i   = int'(wcount);
        free_w = DEPTH - cnt_i;
        wr_req = wen && !clear && (wc_i != 0);
        wr_fit = (wc_i <= PAR_WRITE) && (wc_i <= free_w);
        wr_acc = wr_req && wr_fit;
        wr_rej = wr_req && !wr_fit;
        rd_acc = ren && !clear && (cnt_i >= PAR_READ);
        rd_rej = ren && !clear && (cnt_i < PAR_READ);
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_add(wr_ptr_q, wc_i);
            if (rd_acc) rd_ptr_d = ptr_add(rd_ptr_q, PAR_READ);
            count_d = CNT_W'(cnt_i + (wr_acc ? wc_i : 0) - (rd_acc ? PAR_READ : 0));
            ovf_d   = ovf_q | wr_rej;
            udf_d   = udf_q | rd_rej;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array (never reset): lanes 0..wcount-1 land at consecutive slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
            if (wr_acc && (i < wc_i)) begin
                mem_q[ptr_add(wr_ptr_q, i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Head window presented combinationally; zero whenever a full pop is not available.
    always_comb begin
        dout = '0;
        if (!empty) begin
            for (int j = 0; j < PAR_READ; j++) begin
                dout[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[ptr_add(rd_ptr_q, j)];
            end
        end
    end

    assign count        = count_q;
    assign full         = (free_w < PAR_WRITE);
    assign empty        = (cnt_i < PAR_READ);
    assign almost_full  = (cnt_i >= AF_LEVEL);
    assign almost_empty = (cnt_i <= AE_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_par_fifo_buffer.sv
// Scoreboard bench for par_fifo_buffer: the driver updates a queue-based
// reference model for every applied cycle and pushes the expected post-edge
// outputs; an independent monitor pops and compares after each clock edge.
module tb_par_fifo_buffer;

    localparam int DW    = 16;
    localparam int PW    = 4;
    localparam int PR    = 2;
    localparam int DEPTH = 10;
    localparam int AF    = 8;
    localparam int AE    = 2;
    localparam int WC_W  = $clog2(PW + 1);
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              clear;
    logic              wen;
    logic [WC_W-1:0]   wcount;
    logic [PW*DW-1:0]  din;
    logic              ren;
    logic [PR*DW-1:0]  dout;
    logic [CW-1:0]     count;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;

    typedef struct {
        logic [CW-1:0]    cnt;
        logic             full;
        logic             empty;
        logic             af;
        logic             ae;
        logic             ov;
        logic             un;
        logic [PR*DW-1:0] dout;
    } exp_t;

    exp_t            exp_q[$];
    logic [DW-1:0]   mdl[$];
    bit              m_ov, m_un;
    int              n_vec = 0;
    int              n_err = 0;

    par_fifo_buffer #(
        .DATA_WIDTH(DW), .PAR_WRITE(PW), .PAR_READ(PR),
        .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .wcount(wcount),
        .din(din), .ren(ren), .dout(dout), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic check_state(input exp_t e);
        chk1("count",        64'(count),        64'(e.cnt));
        chk1("full",         64'(full),         64'(e.full));
        chk1("empty",        64'(empty),        64'(e.empty));
        chk1("almost_full",  64'(almost_full),  64'(e.af));
        chk1("almost_empty", 64'(almost_empty), 64'(e.ae));
        chk1("overflow",     64'(overflow),     64'(e.ov));
        chk1("underflow",    64'(underflow),    64'(e.un));
        chk1("dout",         64'(dout),         64'(e.dout));
    endtask

    // Expected outputs derived from the model contents.
    function automatic exp_t model_outputs();
        exp_t e;
        int   sz;
        sz      = mdl.size();
        e.cnt   = CW'(sz);
        e.full  = (DEPTH - sz) < PW;
        e.empty = sz < PR;
        e.af    = sz >= AF;
        e.ae    = sz <= AE;
        e.ov    = m_ov;
        e.un    = m_un;
        e.dout  = '0;
        if (sz >= PR) begin
            for (int j = 0; j < PR; j++) e.dout[j*DW +: DW] = mdl[j];
        end
        return e;
    endfunction

    // Reference model: FIFO as a word queue, acceptance judged on pre-edge size.
    task automatic model_apply(input bit w, input int wc, input logic [PW*DW-1:0] d,
                               input bit r, input bit c);
        int sz;
        bit wok, wrej, rok;
        sz = mdl.size();
        if (c) begin
            mdl.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            wok  = w && (wc >= 1) && (wc <= PW) && (wc <= DEPTH - sz);
            wrej = w && (wc != 0) && !wok;
            rok  = r && (sz >= PR);
            if (wrej) m_ov = 1;
            if (r && !rok) m_un = 1;
            if (rok) for (int k = 0; k < PR; k++) mdl.delete(0);
            if (wok) for (int k = 0; k < wc; k++) mdl.push_back(d[k*DW +: DW]);
        end
        exp_q.push_back(model_outputs());
    endtask

    // One cycle of stimulus, applied after the monitor has sampled.
    task automatic step(input bit w, input int wc, input logic [PW*DW-1:0] d,
                        input bit r, input bit c);
        @(posedge clk);
        #3;
        wen    = w;
        wcount = WC_W'(wc);
        din    = d;
        ren    = r;
        clear  = c;
        model_apply(w, wc, d, r, c);
    endtask

    function automatic logic [PW*DW-1:0] seq(input int base);
        logic [PW*DW-1:0] v;
        for (int k = 0; k < PW; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    function automatic logic [PW*DW-1:0] rnd_din();
        logic [PW*DW-1:0] v;
        for (int k = 0; k < PW; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Monitor: after every edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state(e);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rst_e;
        int   wc;
        rst_e.cnt = '0; rst_e.full = 1'b0; rst_e.empty = 1'b1; rst_e.af = 1'b0;
        rst_e.ae = 1'b1; rst_e.ov = 1'b0; rst_e.un = 1'b0; rst_e.dout = '0;

        rstn = 1'b0; clear = 1'b0; wen = 1'b0; wcount = '0; din = '0; ren = 1'b0;
        m_ov = 0; m_un = 0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;

        // Asynchronous reset mid-operation, checked before any clock edge.
        step(1, 1, seq(16'h0011), 0, 0);
        step(1, 1, seq(16'h0022), 0, 0);
        step(1, 1, seq(16'h0033), 0, 0);
        step(0, 0, '0, 0, 0);
        #2;
        rstn = 1'b0;
        wen  = 1'b0;
        #1;
        check_state(rst_e);
        exp_q.delete();
        mdl.delete();
        m_ov = 0; m_un = 0;
        @(posedge clk);
        #3 rstn = 1'b1;

        // Lane ordering and first-word-fall-through.
        step(1, 4, seq(1), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);

        // Fill up to full, partial write while full, then overflow.
        step(1, 4, seq(16'h0100), 0, 0);
        step(1, 4, seq(16'h0104), 0, 0);
        step(1, 2, seq(16'h0108), 0, 0);
        step(1, 1, seq(16'h010A), 0, 0);
        step(0, 0, '0, 0, 1);

        // Wrap-around of both pointers.
        step(1, 4, seq(1), 0, 0);
        step(1, 4, seq(5), 0, 0);
        step(1, 2, seq(9), 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 0);
        step(1, 4, seq(11), 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, '0, 1, 0);

        // Simultaneous read and write, write judged on pre-edge free space.
        step(1, 4, seq(16'h0200), 0, 0);
        step(1, 4, seq(16'h0204), 0, 0);
        step(1, 4, seq(16'h0208), 1, 0);
        step(1, 2, seq(16'h020C), 1, 0);
        step(0, 0, '0, 0, 1);

        // Underflow, then clear winning over a write; zero-lane write is a no-op.
        step(1, 1, seq(16'h0300), 0, 0);
        step(0, 0, '0, 1, 0);
        step(1, 0, seq(16'h0301), 0, 0);
        step(1, 4, seq(16'h0302), 0, 1);
        step(0, 0, '0, 0, 0);

        // Randomized traffic including illegal lane counts and occasional clears.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) wc = $urandom_range(5, 7);
            else                           wc = $urandom_range(0, 4);
            step($urandom_range(0, 9) < 6, wc, rnd_din(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
        end
        step(0, 0, '0, 0, 0);

        @(posedge clk);
        #5;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/par_fifo_buffer.md
Name: par_fifo_buffer

Overview:
- Next-generation parametrised FIFO for the PE input, filter, psum and output buffers.
- Generalises the fixed-width buffer in four ways: a variable number of valid lanes per write, a non-power-of-two DEPTH, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- First-word-fall-through: the oldest PAR_READ words are always presented on dout.

Parameters:
- DATA_WIDTH, 16, bits per word.
- PAR_WRITE, 4, maximum words written per cycle.
- PAR_READ, 2, words popped per accepted read.
- DEPTH, 10, storage in words. Must satisfy DEPTH >= max(PAR_WRITE, PAR_READ). Any integer is legal (not restricted to powers of two).
- AF_LEVEL, 8, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous flush.
- wen  in  1  write request.
- wcount  in  $clog2(PAR_WRITE+1)  number of valid lanes in din, starting at lane 0.
- din  in  PAR_WRITE*DATA_WIDTH  write data; lane i = din[i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the oldest.
- ren  in  1  read request (pops PAR_READ words).
- dout  out  PAR_READ*DATA_WIDTH  head words; lane 0 is the oldest.
- count  out  $clog2(DEPTH+1)  occupancy in words.
- full  out  1  free < PAR_WRITE.
- empty  out  1  count < PAR_READ.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array (not reset). Registered wr_ptr, rd_ptr and count. free = DEPTH - count.
- Pointers advance modulo DEPTH: ptr_next = ptr + n, minus DEPTH if the sum >= DEPTH. No power-of-two masking.
- Write acceptance: wen && 1 <= wcount <= PAR_WRITE && wcount <= free, where free is the pre-edge value.
  - A read in the same cycle does NOT create room for the write.
  - Accepted: lanes 0..wcount-1 go to wr_ptr, wr_ptr+1, ... (with wrap).
  - wen with wcount=0 is a no-op and does not raise an error.
  - wen with wcount > free or wcount > PAR_WRITE: write rejected, nothing stored, overflow <= 1.
- Partial writes are accepted while full=1 if they fit (full is advisory for a full-width write).
- Read acceptance: ren && count >= PAR_READ.
  - Accepted: rd_ptr advances by PAR_READ.
  - Rejected: underflow <= 1; pointers and count unchanged.
- Simultaneous accepted read and write: count_next = count + wcount - PAR_READ. Data ordering is preserved.
- dout is combinational from the array at rd_ptr .. rd_ptr+PAR_READ-1 (with wrap). It is forced to 0 while empty=1.
- Latency: a word written at edge N is visible on dout after edge N if it is at the head. Flags and count are combinational from registered count, so they change right after the accepting edge.
- clear (synchronous) sets pointers=0, count=0, overflow=0, underflow=0.
  - clear has priority over wen/ren in the same cycle; those requests are dropped and raise no error flag.
- Reset (rstn low, any time, including mid-operation) asynchronously forces: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0. Array contents are undefined.
- overflow and underflow are cleared only by clear or reset.

Test Plan (defaults: DATA_WIDTH=16, PAR_WRITE=4, PAR_READ=2, DEPTH=10, AF_LEVEL=8, AE_LEVEL=2):
1. Reset: after 3 writes, pull rstn low between edges -> count=0, empty=1, almost_empty=1, overflow=underflow=0, dout=0 immediately, without waiting for a clock edge.
2. Ordering: write wcount=4 with {0x0004,0x0003,0x0002,0x0001} (lane0=0x0001) -> count=4, dout={0x0002,0x0001}. Then ren -> dout={0x0004,0x0003}, count=2, almost_empty=1.
3. Fill/overflow:
   - From empty, write 4, then 4 -> count=8, full=1, almost_full=1.
   - Write wcount=2 -> accepted, count=10.
   - Write wcount=1 -> rejected, overflow=1, count=10.
4. Wrap: fill 10 words (values 1..10), read 3 times -> dout shows pairs 1/2, 3/4, 5/6. Write 4 words 11..14 (crosses index 9->0) -> subsequent reads return 7,8,9,10,11,12,13,14 in order.
5. Simultaneous access:
   - count=8, ren + wen wcount=4 -> write rejected (free=2 pre-edge), read accepted, count=6, overflow=1.
   - count=6, ren + wen wcount=2 -> count=6, no error.
6. Underflow/clear:
   - count=1, ren -> underflow=1, count=1, empty=1.
   - clear together with wen wcount=4 -> count=0, overflow=0, underflow=0, write dropped.
